// File: rtl/uart_sram_pkg.sv
// Shared types and byte constants for the UART-to-SRAM host command responder.
package uart_sram_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_RD_WAIT,
        ST_RESP
    } state_e;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] CMD_NEXT = 8'h4E;

    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

endpackage

// File: rtl/sram_cycle_timer.sv
// Loadable 4-bit down-counter; done is high during the last cycle of a loaded interval.
module sram_cycle_timer (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       done
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 4'd1);

endmodule

// File: rtl/uart_sram_responder.sv
// Host command responder: decodes W/R/N byte frames from the UART and runs timed
// async-SRAM cycles, answering each command with one response byte.
module uart_sram_responder
    import uart_sram_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int          WR_PULSE = 2,
    parameter int          RD_WAIT  = 2,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dout,
    input  logic [7:0]        sram_din,
    output logic              sram_oe,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [7:0]        addr_lo_q, addr_lo_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [7:0]        sram_dout_q, sram_dout_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              sram_oe_q, sram_oe_d;
    logic [15:0]       to_q, to_d;

    logic       rx_fire, tx_fire, collecting, to_expired;
    logic       tmr_load, tmr_done;
    logic [3:0] tmr_val;

    function automatic logic [ADDR_W-1:0] make_addr(input logic [7:0] hi, input logic [7:0] lo);
        return ADDR_W'({hi, lo});
    endfunction

    sram_cycle_timer u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign collecting = (state_q == ST_ADDR_HI) || (state_q == ST_ADDR_LO) || (state_q == ST_DATA);
    assign rx_ready   = (state_q == ST_IDLE) || collecting;
    assign tx_valid   = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign rx_fire    = rx_valid && rx_ready;
    assign tx_fire    = tx_valid && tx_ready;
    assign to_expired = (to_q == TIMEOUT - 16'd1);

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_hi_d   = addr_hi_q;
        addr_lo_d   = addr_lo_q;
        sram_addr_d = sram_addr_q;
        last_addr_d = last_addr_q;
        sram_dout_d = sram_dout_q;
        tx_data_d   = tx_data_q;
        tmr_load    = 1'b0;
        tmr_val     = 4'd0;
        to_d        = (collecting && !rx_fire && !to_expired) ? to_q + 16'd1 : 16'd0;

        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    cmd_d = rx_data;
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        state_d = ST_ADDR_HI;
                    end else if (rx_data == CMD_NEXT) begin
                        sram_addr_d = last_addr_q + ADDR_W'(1);
                        last_addr_d = last_addr_q + ADDR_W'(1);
                        tmr_load    = 1'b1;
                        tmr_val     = 4'(RD_WAIT);
                        state_d     = ST_RD_WAIT;
                    end else begin
                        tx_data_d = RSP_ERR;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_ADDR_HI: begin
                if (rx_fire) begin
                    addr_hi_d = rx_data;
                    state_d   = ST_ADDR_LO;
                end else if (to_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR_LO: begin
                if (rx_fire) begin
                    if (cmd_q == CMD_RD) begin
                        sram_addr_d = make_addr(addr_hi_q, rx_data);
                        last_addr_d = make_addr(addr_hi_q, rx_data);
                        tmr_load    = 1'b1;
                        tmr_val     = 4'(RD_WAIT);
                        state_d     = ST_RD_WAIT;
                    end else begin
                        addr_lo_d = rx_data;
                        state_d   = ST_DATA;
                    end
                end else if (to_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx_fire) begin
                    sram_addr_d = make_addr(addr_hi_q, addr_lo_q);
                    last_addr_d = make_addr(addr_hi_q, addr_lo_q);
                    sram_dout_d = rx_data;
                    state_d     = ST_WR_SETUP;
                end else if (to_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_SETUP: begin
                tmr_load = 1'b1;
                tmr_val  = 4'(WR_PULSE);
                state_d  = ST_WR_STROBE;
            end
            ST_WR_STROBE: begin
                if (tmr_done) state_d = ST_WR_HOLD;
            end
            ST_WR_HOLD: begin
                tx_data_d = RSP_OK;
                state_d   = ST_RESP;
            end
            ST_RD_WAIT: begin
                if (tmr_done) begin
                    tx_data_d = sram_din;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (tx_fire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobe is a registered decode of the next state, so it cannot glitch.
        sram_oe_d = (state_d == ST_WR_STROBE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 8'h00;
            addr_hi_q   <= 8'h00;
            addr_lo_q   <= 8'h00;
            sram_addr_q <= '0;
            last_addr_q <= '0;
            sram_dout_q <= 8'h00;
            tx_data_q   <= 8'h00;
            sram_oe_q   <= 1'b0;
            to_q        <= 16'd0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_hi_q   <= addr_hi_d;
            addr_lo_q   <= addr_lo_d;
            sram_addr_q <= sram_addr_d;
            last_addr_q <= last_addr_d;
            sram_dout_q <= sram_dout_d;
            tx_data_q   <= tx_data_d;
            sram_oe_q   <= sram_oe_d;
            to_q        <= to_d;
        end
    end

    assign sram_addr = sram_addr_q;
    assign sram_dout = sram_dout_q;
    assign sram_oe   = sram_oe_q;
    assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_sram_responder.sv
// Directed bench for uart_sram_responder: command frames, SRAM strobe timing, wrap, timeout, stalls, reset.
module tb_uart_sram_responder;

    localparam int TIMEOUT = 50000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [15:0] sram_addr;
    logic [7:0]  sram_dout;
    logic [7:0]  sram_din;
    logic        sram_oe;
    logic        busy;

    int checks = 0;
    int failures = 0;

    int oe_cycles = 0;
    int tx_cycles = 0;
    int tx_fires = 0;
    int stab_errs = 0;
    logic        prev_oe = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    logic [7:0]  prev_dout = 8'h0;

    always #5 clk = ~clk;

    uart_sram_responder #(
        .ADDR_W   (16),
        .WR_PULSE (2),
        .RD_WAIT  (2),
        .TIMEOUT  (16'd50000)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout),
        .sram_din  (sram_din),
        .sram_oe   (sram_oe),
        .busy      (busy)
    );

    // Read-only SRAM contents: a few fixed cells, everything else a simple address hash.
    function automatic logic [7:0] mem_model(input logic [15:0] a);
        case (a)
            16'h1234: return 8'h5A;
            16'hFFFF: return 8'hC3;
            16'h0000: return 8'h81;
            16'h0001: return 8'h7E;
            default:  return a[7:0] ^ a[15:8];
        endcase
    endfunction

    assign sram_din = mem_model(sram_addr);

    always @(negedge clk) begin
        if (sram_oe) oe_cycles++;
        if (tx_valid) tx_cycles++;
        if (tx_valid && tx_ready) tx_fires++;
        if (sram_oe && prev_oe && (sram_addr !== prev_addr || sram_dout !== prev_dout)) stab_errs++;
        prev_oe   = sram_oe;
        prev_addr = sram_addr;
        prev_dout = sram_dout;
    end

    // Returns #1 after the edge on which the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL send_byte_%02h: rx_ready stayed 0 for %0d cycles, required 1", b, n);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Called #1 after the accepting edge; edges counts that edge as 1.
    task automatic wait_tx(output logic [7:0] data, output int edges);
        edges = 1;
        while (!tx_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        data = tx_data;
    endtask

    task automatic finish_tx();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (sram_oe !== 1'b0) begin failures++; $display("FAIL reset_sram_oe: got %b want 0", sram_oe); end
        checks++; if (sram_addr !== 16'h0000) begin failures++; $display("FAIL reset_sram_addr: got %h want 0000", sram_addr); end
        checks++; if (sram_dout !== 8'h00) begin failures++; $display("FAIL reset_sram_dout: got %h want 00", sram_dout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] d;
        int lat;
        int oe0 = oe_cycles;
        int st0 = stab_errs;
        send_byte(8'h57);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hA5);
        checks++; if (sram_addr !== 16'h1234) begin failures++; $display("FAIL wr_setup_addr: got %h want 1234", sram_addr); end
        checks++; if (sram_dout !== 8'hA5) begin failures++; $display("FAIL wr_setup_dout: got %h want a5", sram_dout); end
        checks++; if (sram_oe !== 1'b0) begin failures++; $display("FAIL wr_setup_oe: got %b want 0", sram_oe); end
        @(posedge clk);
        #1;
        checks++; if (sram_oe !== 1'b1) begin failures++; $display("FAIL wr_strobe_oe: got %b want 1", sram_oe); end
        wait_tx(d, lat);
        lat = lat + 1;
        checks++; if (lat !== 5) begin failures++; $display("FAIL wr_latency: got %0d want 5", lat); end
        checks++; if (d !== 8'h4B) begin failures++; $display("FAIL wr_resp: got %h want 4b", d); end
        finish_tx();
        checks++; if (oe_cycles - oe0 !== 2) begin failures++; $display("FAIL wr_oe_cycles: got %0d want 2", oe_cycles - oe0); end
        checks++; if (stab_errs - st0 !== 0) begin failures++; $display("FAIL wr_stability: got %0d changes want 0", stab_errs - st0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after: got %b want 0", busy); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL wr_tx_valid_after: got %b want 0", tx_valid); end
    endtask

    task automatic test_read();
        logic [7:0] d;
        int lat;
        int oe0 = oe_cycles;
        send_byte(8'h52);
        send_byte(8'h12);
        send_byte(8'h34);
        wait_tx(d, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency: got %0d want 3", lat); end
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL rd_data: got %h want 5a", d); end
        finish_tx();
        checks++; if (oe_cycles - oe0 !== 0) begin failures++; $display("FAIL rd_oe_cycles: got %0d want 0", oe_cycles - oe0); end
    endtask

    task automatic test_next_wrap();
        logic [7:0] d;
        int lat;
        send_byte(8'h52);
        send_byte(8'hFF);
        send_byte(8'hFF);
        wait_tx(d, lat);
        checks++; if (d !== 8'hC3) begin failures++; $display("FAIL rd_ffff_data: got %h want c3", d); end
        finish_tx();
        send_byte(8'h4E);
        checks++; if (sram_addr !== 16'h0000) begin failures++; $display("FAIL next_wrap_addr: got %h want 0000", sram_addr); end
        wait_tx(d, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL next_latency: got %0d want 3", lat); end
        checks++; if (d !== 8'h81) begin failures++; $display("FAIL next_wrap_data: got %h want 81", d); end
        finish_tx();
        send_byte(8'h4E);
        checks++; if (sram_addr !== 16'h0001) begin failures++; $display("FAIL next_inc_addr: got %h want 0001", sram_addr); end
        wait_tx(d, lat);
        checks++; if (d !== 8'h7E) begin failures++; $display("FAIL next_inc_data: got %h want 7e", d); end
        finish_tx();
    endtask

    task automatic test_bad_cmd();
        logic [7:0] d;
        int lat;
        int oe0 = oe_cycles;
        send_byte(8'h00);
        wait_tx(d, lat);
        checks++; if (d !== 8'h3F) begin failures++; $display("FAIL bad_cmd_resp: got %h want 3f", d); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL bad_cmd_latency: got %0d want 1", lat); end
        finish_tx();
        checks++; if (sram_addr !== 16'h0001) begin failures++; $display("FAIL bad_cmd_addr: got %h want 0001", sram_addr); end
        checks++; if (oe_cycles - oe0 !== 0) begin failures++; $display("FAIL bad_cmd_oe: got %0d want 0", oe_cycles - oe0); end
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        int lat;
        int oe0 = oe_cycles;
        int tx0;
        send_byte(8'h57);
        send_byte(8'h12);
        tx0 = tx_cycles;
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL timeout_early_busy: got %b want 1", busy); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_idle_busy: got %b want 0", busy); end
        checks++; if (tx_cycles - tx0 !== 0) begin failures++; $display("FAIL timeout_tx: got %0d tx cycles want 0", tx_cycles - tx0); end
        checks++; if (oe_cycles - oe0 !== 0) begin failures++; $display("FAIL timeout_oe: got %0d want 0", oe_cycles - oe0); end
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h01);
        wait_tx(d, lat);
        checks++; if (d !== 8'h7E) begin failures++; $display("FAIL timeout_recover_data: got %h want 7e", d); end
        finish_tx();
    endtask

    task automatic test_back_pressure();
        logic [7:0] d;
        int lat;
        int errs = 0;
        int f0;
        tx_ready = 1'b0;
        send_byte(8'h52);
        send_byte(8'h12);
        send_byte(8'h34);
        wait_tx(d, lat);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL stall_data: got %h want 5a", d); end
        @(negedge clk);
        rx_data  = 8'h52;
        rx_valid = 1'b1;
        f0 = tx_fires;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== 8'h5A || rx_ready !== 1'b0) errs++;
        end
        rx_valid = 1'b0;
        checks++; if (errs !== 0) begin failures++; $display("FAIL stall_hold: got %0d unstable cycles want 0", errs); end
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL stall_release_valid: got %b want 0", tx_valid); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (tx_fires - f0 !== 1) begin failures++; $display("FAIL stall_single_fire: got %0d want 1", tx_fires - f0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_write();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h77);
        @(posedge clk);
        #1;
        checks++; if (sram_oe !== 1'b1) begin failures++; $display("FAIL midrst_pre_oe: got %b want 1", sram_oe); end
        #1 resetn = 1'b0;
        #1;
        checks++; if (sram_oe !== 1'b0) begin failures++; $display("FAIL midrst_oe: got %b want 0", sram_oe); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL midrst_tx_valid: got %b want 0", tx_valid); end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL midrst_rx_ready: got %b want 1", rx_ready); end
        checks++; if (sram_addr !== 16'h0000) begin failures++; $display("FAIL midrst_addr: got %h want 0000", sram_addr); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_next_wrap();
        test_bad_cmd();
        test_timeout();
        test_back_pressure();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
